// File: rtl/mips_fetch_unit.sv
// Fetch end of the multicycle MIPS control loop: program counter, instruction
// memory and instruction register. It takes the FSM's fetch/PC controls and
// returns the opcode/funct fields for decode.
module mips_fetch_unit #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resete,
  input  logic          IRWrite,
  input  logic          PCWrite,
  input  logic          Branch,
  input  logic          zero,
  input  logic [1:0]    PCSrc,
  input  logic [31:0]   alu_result,
  input  logic [31:0]   alu_out,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  output logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic [5:0]    opcode,
  output logic [5:0]    funct,
  output logic          instr_valid,
  output logic          fault,
  output logic [15:0]   fetch_count
);

  logic [31:0]   mem [DEPTH];
  logic          pc_en;
  logic [31:0]   pc_next;
  logic [AW-1:0] index;
  logic          bad_fetch;

  assign pc_en     = PCWrite | (Branch & zero);
  assign index     = pc[AW+1:2];
  // Misaligned or beyond the memory: fetch a nop instead of aliasing.
  assign bad_fetch = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];

  // Next-PC select; jump target is built from the IR before any same-cycle fetch.
  always_comb begin
    pc_next = pc;
    case (PCSrc)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = alu_out;
      2'b10:   pc_next = {pc[31:28], instr[25:0], 2'b00};
      default: pc_next = pc;
    endcase
  end

  // Program-load port; memory is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // PC, IR and fetch bookkeeping. The IR read samples the memory before a
  // same-edge program write lands, giving read-before-write on collision.
  always_ff @(posedge clock) begin
    if (!resete) begin
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (pc_en) pc <= pc_next;
      if (IRWrite) begin
        instr_valid <= 1'b1;
        if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
        if (bad_fetch) begin
          instr <= '0;
          fault <= 1'b1;
        end else begin
          instr <= mem[index];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic          clock = 1'b0;
  logic          resete;
  logic          IRWrite, PCWrite, Branch, zero;
  logic [1:0]    PCSrc;
  logic [31:0]   alu_result, alu_out;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [31:0]   pc, instr;
  logic [5:0]    opcode, funct;
  logic          instr_valid, fault;
  logic [15:0]   fetch_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  mips_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clock(clock), .resete(resete), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .zero(zero), .PCSrc(PCSrc), .alu_result(alu_result),
    .alu_out(alu_out), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .pc(pc), .instr(instr), .opcode(opcode),
    .funct(funct), .instr_valid(instr_valid), .fault(fault),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  // One clock edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_state();
    chk(pc);
    chk(instr);
    chk({31'd0, instr_valid});
    chk({31'd0, fault});
    chk({16'd0, fetch_count});
  endtask

  task automatic exp_state(input string t, input logic [31:0] p, input logic [31:0] i,
                           input logic v, input logic f, input logic [15:0] c);
    expect_val({t, "_pc"}, p);
    expect_val({t, "_instr"}, i);
    expect_val({t, "_valid"}, {31'd0, v});
    expect_val({t, "_fault"}, {31'd0, f});
    expect_val({t, "_count"}, {16'd0, c});
  endtask

  initial begin
    resete = 1'b0; IRWrite = 0; PCWrite = 0; Branch = 0; zero = 0; PCSrc = 2'b00;
    alu_result = '0; alu_out = '0; prog_we = 0; prog_addr = '0; prog_data = '0;
    @(posedge clock); #1;

    // Reset held for two cycles while the program is loaded
    prog_we = 1; prog_addr = 5'd0; prog_data = 32'h8C02_0004; step();
    prog_addr = 5'd1; prog_data = 32'h0043_2020; step();
    prog_addr = 5'd16; prog_data = 32'h0800_0003; resete = 1'b1;
    exp_state("reset", 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
    chk_state();
    step();
    prog_we = 0;

    // First fetch (lw)
    IRWrite = 1; PCWrite = 1; PCSrc = 2'b00; alu_result = 32'd4;
    exp_state("fetch1", 32'd4, 32'h8C02_0004, 1'b1, 1'b0, 16'd1);
    expect_val("fetch1_opcode", 32'h23);
    step();
    chk_state(); chk({26'd0, opcode});

    // Second fetch (R-type add)
    alu_result = 32'd8;
    expect_val("fetch2_opcode", 32'h0);
    expect_val("fetch2_funct", 32'h20);
    expect_val("fetch2_pc", 32'd8);
    step();
    chk({26'd0, opcode}); chk({26'd0, funct}); chk(pc);

    // Branch not taken, then taken
    IRWrite = 0; PCWrite = 0; Branch = 1; zero = 0; PCSrc = 2'b01; alu_out = 32'h40;
    expect_val("branch_nt_pc", 32'd8);
    step(); chk(pc);
    zero = 1;
    expect_val("branch_t_pc", 32'h40);
    step(); chk(pc);

    // Fetch the jump word at 0x40, then jump
    Branch = 0; zero = 0; IRWrite = 1;
    expect_val("jfetch_instr", 32'h0800_0003);
    expect_val("jfetch_pc", 32'h40);
    step(); chk(instr); chk(pc);
    IRWrite = 0; PCWrite = 1; PCSrc = 2'b10;
    expect_val("jump_pc", 32'h0000_000C);
    step(); chk(pc);
    PCSrc = 2'b11;
    expect_val("reserved_pc", 32'h0000_000C);
    step(); chk(pc);

    // Misaligned fetch
    PCSrc = 2'b00; alu_result = 32'h6;
    step();
    PCWrite = 0; IRWrite = 1;
    exp_state("misalign", 32'h6, 32'h0, 1'b1, 1'b1, 16'd4);
    step(); chk_state();

    // Good fetch from 0 keeps fault sticky, then out-of-range fetch
    IRWrite = 0; PCWrite = 1; alu_result = 32'h0;
    step();
    IRWrite = 1; alu_result = 32'd128;
    exp_state("goodfetch", 32'd128, 32'h8C02_0004, 1'b1, 1'b1, 16'd5);
    step(); chk_state();
    PCWrite = 0;
    exp_state("range", 32'd128, 32'h0, 1'b1, 1'b1, 16'd6);
    step(); chk_state();

    // Reset mid-operation overrides active controls
    resete = 1'b0; PCWrite = 1;
    exp_state("midreset", 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
    step(); chk_state();
    resete = 1'b1; IRWrite = 0; PCWrite = 0;

    // Same-word collision: read-before-write
    prog_we = 1; prog_addr = 5'd2; prog_data = 32'h1111_1111;
    step();
    prog_we = 0; PCWrite = 1; alu_result = 32'd8;
    step();
    PCWrite = 0; IRWrite = 1; prog_we = 1; prog_data = 32'hDEAD_BEEF;
    expect_val("collide_old", 32'h1111_1111);
    step(); chk(instr);
    prog_we = 0;
    expect_val("collide_new", 32'hDEAD_BEEF);
    expect_val("collide_count", 32'd2);
    step(); chk(instr); chk({16'd0, fetch_count});
    IRWrite = 0;

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Fetch end of the multicycle MIPS control interface. The unit holds the program counter, a small instruction memory and the instruction register. It consumes the control FSM's fetch/PC controls (IRWrite, PCWrite, Branch, PCSrc) and produces the opcode/funct fields the FSM decodes. It sits between the control state machine and the ALU datapath, and closes the loop: FSM outputs go in, FSM inputs come out.

## Interface
- DEPTH, 32: instruction memory size in 32-bit words; power of two, 4..1024.
- AW, $clog2(DEPTH): word-address width of memory and program port.
- clock  in  1  single clock; all state changes on rising edge.
- resete  in  1  reset; synchronous and active-low.
- IRWrite  in  1  latch instruction at current PC into IR.
- PCWrite  in  1  unconditional PC update.
- Branch  in  1  conditional PC update, qualified by zero.
- zero  in  1  ALU zero flag.
- PCSrc  in  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 reserved.
- alu_result  in  32  combinational ALU result (PC+4 during fetch).
- alu_out  in  32  registered ALUOut (branch target).
- prog_we  in  1  program-load write enable.
- prog_addr  in  AW  program-load word address.
- prog_data  in  32  program-load data.
- pc  out  32  current PC.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- instr_valid  out  1  IR holds a fetched word since reset.
- fault  out  1  sticky bad-fetch flag.
- fetch_count  out  16  number of IRWrite cycles, saturating.

## Operation
- Reset (resete=0 at a rising edge), applied regardless of other inputs:
  - pc=0, instr=0, instr_valid=0, fault=0, fetch_count=0.
  - Memory contents are not reset.
- PC update:
  - pc_en = PCWrite | (Branch & zero).
  - When pc_en=1, pc takes the next-PC value selected by PCSrc:
    - 00: alu_result.
    - 01: alu_out.
    - 10: {pc[31:28], instr[25:0], 2'b00}.
    - 11: pc unchanged.
  - Branch=1 with zero=0 and PCWrite=0 leaves pc unchanged.
- Fetch: on IRWrite=1, index = pc[AW+1:2].
  - If pc[1:0]!=0 or pc[31:AW+2]!=0: instr <= 32'h0000_0000 (nop) and fault <= 1.
  - Otherwise instr <= mem[index].
  - In both cases instr_valid <= 1 and fetch_count increments, holding at 16'hFFFF.
- IRWrite and pc_en in the same cycle: the fetch uses the old pc, and pc updates in parallel (standard fetch state: IR<=mem[PC], PC<=PC+4).
- Jump target uses the instr value before any same-cycle IRWrite.
- Program load: prog_we=1 writes prog_data to mem[prog_addr]. A simultaneous IRWrite to the same word returns the old word (read-before-write).
- fault is cleared only by reset.
- opcode and funct are pure slices of instr; there is no separate register for them.

## Timing
- All outputs are registered or slices of registers. There is no combinational path from inputs to outputs.
- Fetch latency 1: the instruction is visible on instr/opcode/funct the cycle after the IRWrite edge, in time for the FSM decode state.
- PC update latency 1: the new pc is visible the cycle after the pc_en edge.
- Written memory data is fetchable on the cycle after the write.
- The control inputs carry no handshake. Each asserted cycle is one action; holding IRWrite for N cycles performs N fetches from the same pc unless pc also changes.
- Reset mid-operation takes priority over every input on that edge. The cycle after, pc=0 and instr_valid=0.

## Test plan
- Reset/load/first fetch:
  - Stimulus: hold resete=0 for 2 cycles; load mem[0]=32'h8C02_0004, mem[1]=32'h0043_2020; release reset; IRWrite=1, PCWrite=1, PCSrc=00, alu_result=4.
  - Required: next cycle instr=32'h8C02_0004, opcode=100011, pc=4, instr_valid=1, fetch_count=1.
- Second fetch (R-type):
  - Stimulus: from pc=4, IRWrite=1, PCWrite=1, alu_result=8.
  - Required: opcode=000000, funct=100000, pc=8.
- Branch:
  - Stimulus: Branch=1, zero=0, PCSrc=01, alu_out=32'h40.
  - Required: pc unchanged.
  - Stimulus: repeat with zero=1.
  - Required: pc=32'h40.
- Jump:
  - Stimulus: instr=32'h0800_0003, PCWrite=1, PCSrc=10.
  - Required: pc=32'h0000_000C.
  - Stimulus: PCSrc=11.
  - Required: pc holds.
- Bad fetch:
  - Stimulus: pc=32'h6 (misaligned), IRWrite=1.
  - Required: instr=0, fault=1.
  - Stimulus: pc=4*DEPTH (=128), IRWrite=1.
  - Required: instr=0, fault stays 1.
  - Stimulus: assert resete=0.
  - Required: fault=0, pc=0, fetch_count=0.
- Same-word collision:
  - Stimulus: prog_we=1 to word 2 with 32'hDEAD_BEEF while IRWrite=1 at pc=8 (old word 32'h1111_1111).
  - Required: instr=32'h1111_1111; a repeat fetch returns 32'hDEAD_BEEF.
